tail_light_seq: RTL and testbench
=================================

# tail_light_seq

Parametrised sequential turn-signal and hazard controller for the tail-light lab datapath, generalising the fixed three-lamp left/right/hazard FSM. Drives N lamps per side with an outward-growing "Thunderbird" sequence, a programmable step rate via an internal clock divider, and a brake override. It sits between the debounced switch inputs and the lamp driver outputs.

## Interface

- N, default 3: lamps per side, N >= 1; bit 0 is the innermost lamp.
- DIV, default 1: clock cycles per sequence step, DIV >= 1; DIV=1 steps every cycle.

- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; one clock and reset, both fixed.
- L  input  1  left turn request, level.
- R  input  1  right turn request, level.
- B  input  1  brake, level.
- lamp_l  output  N  left lamps, 1 = on.
- lamp_r  output  N  right lamps, 1 = on.
- busy  output  1  high whenever mode != IDLE.

## Operation

- Registers: mode {IDLE, LEFT, RIGHT, HAZ}, step counter k (width $clog2(N+1), range 1..N when active, 0 in IDLE), divider d (0..DIV-1), brake_q.
- Divider: d increments every cycle, wraps DIV-1 -> 0; tick = (d == DIV-1). Free-running; never cleared except by reset. mode/k change only on cycles with tick=1.
- IDLE on tick: L&R -> HAZ,k=1; else L -> LEFT,k=1; else R -> RIGHT,k=1; else stay.
- LEFT on tick: if R (L ignored) -> IDLE; else if k==N -> IDLE; else k+1. Releasing L does not cancel a sequence in progress.
- RIGHT: mirror of LEFT with L as cancel.
- HAZ on tick: if L^R -> IDLE; else if k==N -> IDLE; else k+1. L=R=0 does not cancel.
- When k==N the next tick always returns to IDLE (one all-off step) regardless of inputs; a held request restarts from k=1 on the following tick.
- Lamp pattern for active side at step k: low k bits set, i.e. (1<<k)-1. N=3: 001, 011, 111.
- Output decode (combinational from mode, k, brake_q):
  - IDLE: both sides = brake_q ? all-ones : 0.
  - LEFT: lamp_l = pattern(k); lamp_r = brake_q ? all-ones : 0.
  - RIGHT: mirror.
  - HAZ: both sides = pattern(k); brake ignored.
- busy = (mode != IDLE).
- Unreachable encodings of mode or k > N: return to IDLE, k=0 on next cycle (not gated by tick).

## Timing

- Reset (synchronous, sampled at clk edge): mode=IDLE, k=0, d=0, brake_q=0; lamp_l=0, lamp_r=0, busy=0 from that edge. Reset mid-sequence aborts immediately with same values; no partial pattern survives.
- First tick after reset is DIV cycles after reset deasserts (d counts 0..DIV-1).
- L/R sampled only on tick cycles; pulses shorter than DIV may be missed (by design).
- Request-to-first-lamp latency: request sampled at tick edge T, lamp on from T (cycle after sample). With DIV=1: L asserted in cycle c -> lamp_l=001 in cycle c+1.
- Each active step and the terminal IDLE step last exactly DIV cycles.
- Full sequence period with request held: (N+1)*DIV cycles.
- Brake: B -> brake_q one cycle, independent of tick; lamp effect one cycle after B.

## Test plan

- Reset: N=3, DIV=1, drive L=R=B=1 during reset -> lamp_l=lamp_r=000, busy=0 every reset cycle.
- Left sequence: N=3, DIV=1, L=1 held from cycle 0 -> lamp_l 001, 011, 111, 000, 001 on cycles 1..5; lamp_r=000 throughout; busy 1,1,1,0,1.
- Cancel: N=3, DIV=1, L=1 cycle 0, R=1 in cycle 1 (L held) -> lamp_l 001 then 000 in cycle 2; cycle 3 starts RIGHT only if R alone or HAZ if L&R, checked both ways.
- Hazard: N=4, DIV=1, L=R=1 -> both sides 0001, 0011, 0111, 1111, 0000; repeat with R dropped at step 2 -> both 0000 next cycle.
- Divider: N=3, DIV=4, L held -> each of 001/011/111/000 lasts exactly 4 cycles; period 16.
- Brake + reset mid-op: N=3, DIV=1, B=1 idle -> both 111 one cycle later; L during B -> lamp_l sequences, lamp_r=111; assert reset at step 2 -> all 000, busy=0 at next edge.

Source files
------------

// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_seq
// Purpose  : N-lamp Thunderbird turn/hazard sequencer with step divider and
//            brake override.
// Revision : 1.0 - initial release
// ============================================================================
module tail_light_seq #(
    parameter int N   = 3,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         L,
    input  logic         R,
    input  logic         B,
    output logic [N-1:0] lamp_l,
    output logic [N-1:0] lamp_r,
    output logic         busy
);

    localparam int KW = $clog2(N + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_LEFT  = 2'd1;
    localparam logic [1:0]    c_RIGHT = 2'd2;
    localparam logic [1:0]    c_HAZ   = 2'd3;
    localparam logic [KW-1:0] c_K_ONE = KW'(1);
    localparam logic [KW-1:0] c_K_MAX = KW'(N);
    localparam logic [DW-1:0] c_D_MAX = DW'(DIV - 1);
    localparam logic [DW-1:0] c_D_ONE = DW'(1);

    logic [1:0]    r_mode;
    logic [KW-1:0] r_k;
    logic [DW-1:0] r_d;
    logic          r_brake_q;

    logic [1:0]    w_mode_nx;
    logic [KW-1:0] w_k_nx;
    logic          w_tick;
    logic          w_k_bad;
    logic [N-1:0]  w_pat;
    logic [N-1:0]  w_brake_pat;

    assign w_tick = (r_d == c_D_MAX);

    // Free-running step divider; only reset realigns its phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d       <= '0;
            r_brake_q <= 1'b0;
        end else begin
            r_d       <= w_tick ? '0 : (r_d + c_D_ONE);
            r_brake_q <= B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= c_IDLE;
            r_k    <= '0;
        end else begin
            r_mode <= w_mode_nx;
            r_k    <= w_k_nx;
        end
    end

    // Corrupted step counts recover at once rather than waiting for a tick.
    assign w_k_bad = (int'(r_k) > N) ||
                     ((r_mode == c_IDLE) != (r_k == '0));

    always_comb begin
        w_mode_nx = r_mode;
        w_k_nx    = r_k;
        if (w_k_bad) begin
            w_mode_nx = c_IDLE;
            w_k_nx    = '0;
        end else if (w_tick) begin
            case (r_mode)
                c_IDLE: begin
                    if (L || R) begin
                        w_k_nx = c_K_ONE;
                        if (L && R)
                            w_mode_nx = c_HAZ;
                        else if (L)
                            w_mode_nx = c_LEFT;
                        else
                            w_mode_nx = c_RIGHT;
                    end
                end
                c_LEFT, c_RIGHT, c_HAZ: begin
                    if (((r_mode == c_LEFT)  && R) ||
                        ((r_mode == c_RIGHT) && L) ||
                        ((r_mode == c_HAZ)   && (L ^ R)) ||
                        (r_k == c_K_MAX)) begin
                        w_mode_nx = c_IDLE;
                        w_k_nx    = '0;
                    end else begin
                        w_k_nx = r_k + c_K_ONE;
                    end
                end
                default: begin
                    w_mode_nx = c_IDLE;
                    w_k_nx    = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_pat = '0;
        for (int i = 0; i < N; i++)
            w_pat[i] = (int'(r_k) > i);
    end

    assign w_brake_pat = r_brake_q ? '1 : '0;

    always_comb begin
        lamp_l = w_brake_pat;
        lamp_r = w_brake_pat;
        case (r_mode)
            c_LEFT:  lamp_l = w_pat;
            c_RIGHT: lamp_r = w_pat;
            c_HAZ: begin
                lamp_l = w_pat;
                lamp_r = w_pat;
            end
            default: ;
        endcase
    end

    assign busy = (r_mode != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tail_light_seq
// Purpose  : Directed vector bench for tail_light_seq (three configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tail_light_seq;

    logic       clk = 1'b0;
    logic       reset, L, R, B;
    logic [2:0] a_l, a_r;
    logic       a_busy;
    logic [3:0] b_l, b_r;
    logic       b_busy;
    logic [2:0] c_l, c_r;
    logic       c_busy;

    int checks   = 0;
    int failures = 0;

    tail_light_seq #(.N(3), .DIV(1)) u_a (
        .clk(clk), .reset(reset), .L(L), .R(R), .B(B),
        .lamp_l(a_l), .lamp_r(a_r), .busy(a_busy)
    );
    tail_light_seq #(.N(4), .DIV(1)) u_b (
        .clk(clk), .reset(reset), .L(L), .R(R), .B(B),
        .lamp_l(b_l), .lamp_r(b_r), .busy(b_busy)
    );
    tail_light_seq #(.N(3), .DIV(4)) u_c (
        .clk(clk), .reset(reset), .L(L), .R(R), .B(B),
        .lamp_l(c_l), .lamp_r(c_r), .busy(c_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, l, r, b;
        logic [2:0] el, er;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic l, input logic r, input logic b,
                       input logic [2:0] el, input logic [2:0] er, input logic eb);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.b = b;
        v.el = el; v.er = er; v.ebusy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic l, input logic r, input logic b);
        reset = rst; L = l; R = r; B = b;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b1);

        // Each row: inputs sampled at the next edge, N=3/DIV=1 outputs after it.
        //   rst  L     R     B     lamp_l  lamp_r  busy
        add(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // left sequence with L held, then restart
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1);
        // releasing L lets the sequence finish
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // R cancels left, then R alone starts right
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // R cancels left, then L&R starts hazard; L=R=0 does not cancel it
        add(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b001, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 3'b011, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // brake in idle, brake under a left sequence, reset at step 2
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 3'b111, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 3'b111, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // hazard ignores the brake
        add(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b011, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].b);
            step();
            check("vec_lamp_l", i, int'(a_l), int'(vecs[i].el));
            check("vec_lamp_r", i, int'(a_r), int'(vecs[i].er));
            check("vec_busy",   i, int'(a_busy), int'(vecs[i].ebusy));
        end

        // N=4 hazard: full run, then R dropped at step 2
        begin
            logic [3:0] haz_exp [0:4];
            haz_exp[0] = 4'b0001; haz_exp[1] = 4'b0011; haz_exp[2] = 4'b0111;
            haz_exp[3] = 4'b1111; haz_exp[4] = 4'b0000;
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 5; i++) begin
                step();
                check("haz4_l", i, int'(b_l), int'(haz_exp[i]));
                check("haz4_r", i, int'(b_r), int'(haz_exp[i]));
                check("haz4_busy", i, int'(b_busy), (i < 4) ? 1 : 0);
            end
            step();
            check("haz4_restart", 0, int'(b_l), 4'b0001);
            step();
            check("haz4_step2", 0, int'(b_r), 4'b0011);
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            step();
            check("haz4_drop_l", 0, int'(b_l), 0);
            check("haz4_drop_r", 0, int'(b_r), 0);
            check("haz4_drop_busy", 0, int'(b_busy), 0);
        end

        // N=3, DIV=4: first tick 4 cycles after reset, each step lasts 4 cycles
        begin
            logic [2:0] div_exp [0:3];
            int q;
            int idx;
            div_exp[0] = 3'b001; div_exp[1] = 3'b011;
            div_exp[2] = 3'b111; div_exp[3] = 3'b000;
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            for (int n = 1; n <= 24; n++) begin
                step();
                q   = n / 4;
                idx = (q == 0) ? 3 : ((q - 1) % 4);
                check("div_lamp_l", n, int'(c_l), int'(div_exp[idx]));
                check("div_lamp_r", n, int'(c_r), 0);
                check("div_busy", n, int'(c_busy), (idx != 3) ? 1 : 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
